mem_port_arbiter: RTL

Sequencer and arbiter for the single L2-to-main-memory port. It shares the port between the L2 line-fill requester (read miss) and the L2 write-back requester (dirty eviction). Each granted request runs as a 4-beat burst of 64-bit words, using the main memory's per-beat addrstb/stb handshake. It sits between the L2 cache and main memory and drives the memory-side strobe, write-enable, address and write data.

---
 rtl/mem_port_pkg.sv | 18 +
 rtl/mem_port_arbiter_rr_arb2.sv | 35 +++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_port_pkg.sv
// Shared types, constants and beat-address helper for mem_port_arbiter.
package mem_port_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, BEAT, DONE} portState_t;

  localparam int unsigned BEATS      = 4;
  localparam int unsigned BEAT_W     = $clog2(BEATS);
  localparam int unsigned LINE_OFF_W = 5;
  localparam int unsigned MAX_ADDR_W = 64;
  localparam int unsigned TAG_W      = MAX_ADDR_W - LINE_OFF_W;

  // {line tag, beat index, byte offset of a 64-bit beat}
  function automatic logic [MAX_ADDR_W-1:0] beatAddr(input logic [TAG_W-1:0]  tag,
                                                     input logic [BEAT_W-1:0] beat);
    return {tag, beat, 3'b000};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; override forces the write-back side when both request.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic reqFill,
  input  logic reqWb,
  input  logic override,
  input  logic advance,
  output logic grantFill,
  output logic grantWb
);

  logic ptrWb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptrWb <= 1'b0;
    end else if (advance) begin
      ptrWb <= ~ptrWb;
    end
  end

  always_comb begin
    grantFill = 1'b0;
    grantWb   = 1'b0;
    if (reqFill && reqWb) begin
      if (override || ptrWb) grantWb = 1'b1;
      else                   grantFill = 1'b1;
    end else begin
      grantFill = reqFill;
      grantWb   = reqWb;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the L2 main-memory port between line fills and write-backs as bursts.
// Define MEM_TIMEOUT_EN to abort a beat after TIMEOUT_CYC cycles and set sticky mem_err.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned BEATS       = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_rdata,
  output logic              fill_rvalid,
  output logic              fill_done,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic              wb_wready,
  output logic              wb_done,
  output logic              mem_addrstb,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dout,
  output logic              mem_doe,
  input  logic [DATA_W-1:0] mem_din,
  input  logic              mem_stb,
  output logic              mem_err
);
  import mem_port_pkg::*;

  localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(BEATS - 1);

  portState_t                 state;
  logic [ADDR_W-1:LINE_OFF_W] lineTag;
  logic [ADDR_W-1:LINE_OFF_W] winTag;
  logic [BEAT_W-1:0]          beatCnt;
  logic                       isWrite;
  logic                       grantFill, grantWb, sameLine;
  logic                       beatAck, abort;
  logic                       unusedAddrLow;

  function automatic logic [ADDR_W-1:0] composeAddr(input logic [ADDR_W-1:LINE_OFF_W] tag,
                                                    input logic [BEAT_W-1:0]          beat);
    return ADDR_W'(beatAddr(TAG_W'(tag), beat));
  endfunction

  assign sameLine      = fill_addr[ADDR_W-1:LINE_OFF_W] == wb_addr[ADDR_W-1:LINE_OFF_W];
  assign winTag        = grantWb ? wb_addr[ADDR_W-1:LINE_OFF_W] : fill_addr[ADDR_W-1:LINE_OFF_W];
  assign unusedAddrLow = ^{fill_addr[LINE_OFF_W-1:0], wb_addr[LINE_OFF_W-1:0]};
  assign beatAck       = (state == BEAT) && mem_stb;
  // Gated so nothing of the write-back requester leaks onto the bus outside a write burst.
  assign mem_dout      = mem_doe ? wb_wdata : '0;

  rr_arb2 uArb (
    .clk      (clk),
    .rst_n    (rst_n),
    .reqFill  (fill_req),
    .reqWb    (wb_req),
    .override (sameLine),
    .advance  (state == DONE),
    .grantFill(grantFill),
    .grantWb  (grantWb)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] waitCnt;
  assign abort = (state == BEAT) && !mem_stb && (waitCnt == TmoW'(TIMEOUT_CYC - 1));
`else
  localparam int unsigned unusedTimeout = TIMEOUT_CYC;
  assign abort   = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lineTag     <= '0;
      beatCnt     <= '0;
      isWrite     <= 1'b0;
      fill_rdata  <= '0;
      fill_rvalid <= 1'b0;
      fill_done   <= 1'b0;
      wb_wready   <= 1'b0;
      wb_done     <= 1'b0;
      mem_addrstb <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_doe     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      waitCnt     <= '0;
      mem_err     <= 1'b0;
`endif
    end else begin
      mem_addrstb <= 1'b0;
      fill_rvalid <= 1'b0;
      wb_wready   <= 1'b0;
      fill_done   <= 1'b0;
      wb_done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grantFill || grantWb) begin
            lineTag     <= winTag;
            isWrite     <= grantWb;
            beatCnt     <= '0;
            mem_addrstb <= 1'b1;
            mem_we      <= grantWb;
            mem_doe     <= grantWb;
            mem_addr    <= composeAddr(winTag, '0);
            state       <= ADDR;
`ifdef MEM_TIMEOUT_EN
            waitCnt     <= '0;
`endif
          end
        end
        ADDR: state <= BEAT;
        BEAT: begin
          if (beatAck) begin
            if (isWrite) begin
              wb_wready <= 1'b1;
            end else begin
              fill_rvalid <= 1'b1;
              fill_rdata  <= mem_din;
            end
          end
          if ((beatAck && beatCnt == LastBeat) || abort) begin
            state     <= DONE;
            mem_we    <= 1'b0;
            mem_doe   <= 1'b0;
            mem_addr  <= '0;
            fill_done <= ~isWrite;
            wb_done   <= isWrite;
          end else if (beatAck) begin
            beatCnt     <= beatCnt + 1'b1;
            mem_addrstb <= 1'b1;
            mem_addr    <= composeAddr(lineTag, beatCnt + 1'b1);
            state       <= ADDR;
`ifdef MEM_TIMEOUT_EN
            waitCnt     <= '0;
          end else begin
            waitCnt     <= waitCnt + 1'b1;
`endif
          end
`ifdef MEM_TIMEOUT_EN
          if (abort) mem_err <= 1'b1;
`endif
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule
